// File: rtl/grant_sequencer.sv
// grant_sequencer: registered one-hot grant holder with hold timeout, optional preemption and timeout masking
module grant_sequencer #(
  parameter int N = 8,
  parameter int PRIO_BITS = 3,
  parameter int HOLD_MAX = 16,
  parameter int PREEMPT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic                 arb_req_i,
  input  logic [$clog2(N)-1:0] arb_sel_i,
  input  logic [PRIO_BITS-1:0] arb_prio_i,
  output logic [N-1:0]         mask_o,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_sel_o,
  output logic [PRIO_BITS-1:0] gnt_prio_o,
  output logic                 timeout_o
);
  localparam int CW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] HM1 = CW'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] gnt_n, mask_n;
  logic [$clog2(N)-1:0] sel_n;
  logic [PRIO_BITS-1:0] prio_n;
  logic to_n, take, rel, tmo, pre, start, stay;
  assign take = arb_req_i && req_i[arb_sel_i];
  assign rel = !req_i[gnt_sel_o];
  assign tmo = HOLD_MAX != 0 && cnt == HM1;
  assign pre = PREEMPT != 0 && arb_req_i && arb_prio_i < gnt_prio_o;
  assign start = state == IDLE && take;
  assign stay = state == GRANT && !rel && !tmo && !pre;
  assign gnt_valid_o = |gnt_o;
  // state and all outputs are registered; reset drops any grant immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      gnt_o <= '0;
      gnt_sel_o <= '0;
      gnt_prio_o <= '0;
      mask_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gnt_o <= gnt_n;
      gnt_sel_o <= sel_n;
      gnt_prio_o <= prio_n;
      mask_o <= mask_n;
      timeout_o <= to_n;
    end
  end
  // release beats timeout beats preemption; GAP always lasts one cycle
  always_comb begin
    state_n = state == IDLE  ? (take ? GRANT : IDLE) :
              state == GRANT ? (rel || tmo || pre ? GAP : GRANT) : IDLE;
  end
  // next register values; selection and priority read zero whenever no grant is held
  always_comb begin
    sel_n = start ? arb_sel_i : stay ? gnt_sel_o : '0;
    prio_n = start ? arb_prio_i : stay ? gnt_prio_o : '0;
    gnt_n = start || stay ? N'(1) << sel_n : '0;
    cnt_n = stay ? (&cnt ? cnt : cnt + 1'b1) : '0;
    to_n = state == GRANT && !rel && tmo;
    mask_n = (mask_o & req_i) | (to_n ? N'(1) << gnt_sel_o : '0);
  end
endmodule

// File: doc/grant_sequencer.md
# grant_sequencer

Registered grant-side companion to the combinational priority arbiter. It takes the arbiter's winning request, selection index and priority, issues a one-hot grant back to the selected source, and holds that grant until the source releases its request. It also enforces a maximum hold time, can optionally preempt for a strictly higher priority, and masks timed-out sources from re-arbitration until they drop their request.

## Interface
- N, 8: number of sources; power of two, ≥ 2
- PRIO_BITS, 3: priority width; 0 is highest priority
- HOLD_MAX, 16: maximum grant length in cycles; 0 disables the timeout
- PREEMPT, 0: 1 allows a strictly higher-priority arbiter winner to revoke the current grant
- Reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  N  raw source requests; a source holds its bit high for the whole transaction
- arb_req_i  in  1  arbiter req_o; the arbiter is fed req_i & ~mask_o
- arb_sel_i  in  $clog2(N)  arbiter sel_o
- arb_prio_i  in  PRIO_BITS  arbiter prio_o
- mask_o  out  N  sources blocked from arbitration
- gnt_o  out  N  one-hot grant
- gnt_valid_o  out  1  a grant is active (equals |gnt_o)
- gnt_sel_o  out  $clog2(N)  index of the granted source
- gnt_prio_o  out  PRIO_BITS  priority latched at the time of grant
- timeout_o  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX

## Operation
- **Reset values.** State IDLE; all of gnt_o, gnt_valid_o, gnt_sel_o, gnt_prio_o, mask_o, timeout_o and the hold counter are 0. Reset is asynchronous, so an active grant drops immediately, even mid-transaction.
- **IDLE.** gnt_o = 0.
  - If arb_req_i is high and req_i[arb_sel_i] is high at the edge: latch arb_sel_i into gnt_sel_o and arb_prio_i into gnt_prio_o, set gnt_o[arb_sel_i], clear the counter, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT.** gnt_o[gnt_sel_o] = 1. The counter increments every cycle and saturates. Evaluation order at each edge, first match wins:
  1. **Release.** req_i[gnt_sel_o] = 0: drop the grant and go to GAP.
  2. **Timeout.** HOLD_MAX ≠ 0 and the counter equals HOLD_MAX-1, so the grant has been high HOLD_MAX cycles: drop the grant, set mask_o[gnt_sel_o], pulse timeout_o for the next cycle, and go to GAP.
  3. **Preempt.** PREEMPT = 1, arb_req_i = 1 and arb_prio_i < gnt_prio_o, a strict compare: drop the grant and go to GAP. The preempted source is not masked.
  4. Otherwise stay in GRANT.
- **GAP.** All grants are 0 for exactly one cycle, then go to IDLE. This guarantees no grant overlap.
- **Outputs while not granted.** gnt_sel_o and gnt_prio_o are 0 whenever gnt_valid_o is 0.
- **Masking.**
  - mask_o[i] clears at any edge where req_i[i] = 0.
  - A set and a clear on the same bit at the same edge cannot occur, because timeout requires the request to be high.
  - Masks for other sources clear independently while a grant is active.
- **Counter width.** $clog2(HOLD_MAX+1), minimum 1 bit.
- **Stale arbiter selection.** If arb_req_i is high but req_i[arb_sel_i] is low, no grant is issued.

## Timing
- Every output is driven from registers only; there are no combinational paths from inputs to outputs.
- **Request to grant.** Request seen by the arbiter at edge k, gnt_o high from edge k+1.
- **Release to next grant.** Source drops its request before edge r. Grant low after edge r, GAP for cycle r..r+1, IDLE samples at edge r+2, next grant from edge r+2 at the earliest. Minimum back-to-back grant spacing is 2 low cycles.
- **Maximum grant length.** A grant is high at most HOLD_MAX consecutive cycles.
- **Timeout pulse.** timeout_o is high only in the first GAP cycle.
- **Preemption latency.** With PREEMPT = 1, a higher-priority winner visible at edge p gets its grant no earlier than edge p+2.

## Test plan
- **Reset:** assert rst_i asynchronously mid-clock with a grant active -> gnt_o, mask_o and timeout_o read 0 before the next edge; the grant restarts only after rst_i deasserts.
- **Single request:** req_i=8'h20, arbiter sel=5, prio=3 -> gnt_o=8'h20, gnt_sel_o=5 and gnt_prio_o=3 one cycle later. Drop req_i -> gnt_o=0 next cycle, with one GAP cycle.
- **Back-to-back:** sources 1 (prio 2) and 6 (prio 0) requesting together -> source 6 granted first. Source 6 releases -> exactly 2 cycles with gnt_o=0, then gnt_o=8'h02.
- **Timeout:** HOLD_MAX=4, source 3 holds its request -> gnt_o[3] high for exactly 4 cycles. Then timeout_o pulses once, mask_o=8'h08, and source 3 is not re-granted until req_i[3] is low for one edge.
- **Preempt:** PREEMPT=1, source 2 granted at prio 5, then source 7 raises its request at prio 1 -> grant 2 drops, 1 GAP cycle, then gnt_o=8'h80. A prio-5 competitor does not preempt.
- **Stale selection:** arbiter drives sel=4 while req_i[4]=0 -> no grant is issued; state stays IDLE.
